hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32I core. Drives hold/clear of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers and the operand-forwarding selects for the EX stage. Resolves three hazard classes:
- load-use data hazards;
- taken branches and jumps resolved in EX;
- data-memory wait states, with a timeout fault.

Also keeps saturating event counters for performance debug.

## Interface
- `CNT_W`, 16, width of each event counter
- `MEM_TIMEOUT`, 255, maximum consecutive wait cycles before a fault (1..2^16-1)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock, all state updates on rising edge
- `rst`  in  1  synchronous active-high reset
- `Rs1_ID`, `Rs2_ID`  in  5 each  source registers of the instruction in ID
- `use_rs1_ID`, `use_rs2_ID`  in  1 each  instruction in ID actually reads rs1/rs2
- `Rd_EX`, `Rs1_EX`, `Rs2_EX`  in  5 each  register fields in EX
- `RegWEn_EX`  in  1  EX instruction writes rd
- `WBSel_EX`  in  2  writeback source of EX instruction (2'b01 = load data)
- `PCsel_EX`  in  1  branch/jump taken, resolved in EX
- `Rd_MEM`, `Rd_WB`  in  5 each  destination registers in MEM and WB
- `RegWEn_MEM`, `RegWEn_WB`  in  1 each  write enables in MEM and WB
- `dmem_req_MEM`  in  1  MEM-stage instruction is accessing data memory
- `dmem_ack`  in  1  data memory completes the access this cycle
- `hold_PC`, `hold_IF_ID`, `hold_ID_EX`, `hold_EX_MEM`  out  1 each  register keeps its value
- `clear_IF_ID`, `clear_ID_EX`, `clear_MEM_WB`  out  1 each  register loads a bubble
- `fwdA_sel`, `fwdB_sel`  out  2 each  EX operand source: 00 regfile, 01 WB, 10 MEM
- `mem_fault`  out  1  sticky data-memory timeout flag
- `stall_cnt`, `flush_cnt`, `wait_cnt`  out  CNT_W each  event counters

## Operation
FSM states:
- **RUN**: normal operation.
- **WAIT**: data-memory access outstanding.
- **FAULT**: timeout occurred; terminal until `rst`.

Combinational terms:
- `mw` = `dmem_req_MEM & !dmem_ack`
- `lu` = `RegWEn_EX & WBSel_EX==2'b01 & Rd_EX!=0 & ((use_rs1_ID & Rd_EX==Rs1_ID) | (use_rs2_ID & Rd_EX==Rs2_ID))`
- `br` = `PCsel_EX`

Output priority, evaluated in RUN and WAIT (exactly one case applies):
1. **`mw`**: assert all four holds and `clear_MEM_WB`. No other clear is asserted. `br` and `lu` are deferred, because the held EX contents are re-evaluated next cycle.
2. **`br`**: assert `clear_IF_ID` and `clear_ID_EX`. `lu` is ignored, since the ID instruction is squashed.
3. **`lu`**: assert `hold_PC`, `hold_IF_ID` and `clear_ID_EX`, inserting one bubble.
4. **Otherwise**: all holds and clears are 0.

FSM transitions:
- RUN -> WAIT when `mw`.
- WAIT -> RUN when `dmem_ack`.
- WAIT -> FAULT when the wait counter reaches `MEM_TIMEOUT` and `dmem_ack` is 0.
- FAULT: all holds asserted, all clears 0, `mem_fault` = 1; exits only on `rst`.

Wait counter (internal, 16 bit):
- Cleared in RUN.
- Incremented each cycle in WAIT while `dmem_ack` = 0.

Forwarding (combinational, same rule for B using `Rs2_EX`):
- `fwdA_sel` = 10 if `RegWEn_MEM & Rd_MEM!=0 & Rd_MEM==Rs1_EX`.
- Else 01 if `RegWEn_WB & Rd_WB!=0 & Rd_WB==Rs1_EX`.
- Else 00.
- MEM has priority over WB.

Counters (saturate at all-ones, never wrap; frozen in FAULT):
- `stall_cnt` +1 per cycle in which case 3 (`lu` stall) applies.
- `flush_cnt` +1 per cycle in which case 2 (`br` flush) applies.
- `wait_cnt` +1 per cycle with `mw`.

## Timing
- All hold/clear/fwd outputs are combinational from current inputs and state, and take effect at the next rising edge.
- `mem_fault` and the counters are registered and update one edge after the causing cycle.
- Load-use costs exactly 1 bubble. After that edge ID/EX holds a bubble, so `lu` = 0.
- Taken branch costs 2 squashed instructions, both flushed in the same cycle.
- Memory wait of N cycles holds the pipeline for N cycles. The instruction is released in the cycle `dmem_ack` = 1.
- On reset, at the clock edge with `rst` = 1:
  - state = RUN, wait counter = 0, `mem_fault` = 0, all counters = 0.
  - Outputs are forced to idle during reset: holds 0, clears 0, `fwd*_sel` 00.
- Reset asserted mid-WAIT or in FAULT returns to RUN at that edge, with no extra cycle.

## Test plan
- **Load-use.** `lw x5` in EX (`RegWEn_EX`=1, `WBSel_EX`=01, `Rd_EX`=5); `add x6,x5,x1` in ID (`use_rs1_ID`=1, `Rs1_ID`=5) -> `hold_PC`=`hold_IF_ID`=`clear_ID_EX`=1 for 1 cycle; `stall_cnt`=1 next edge. Repeat with `Rd_EX`=0 -> no stall.
- **Branch beats load-use.** `PCsel_EX`=1 together with a `lu` condition -> `clear_IF_ID`=`clear_ID_EX`=1, holds 0; `flush_cnt`=1, `stall_cnt`=0.
- **Forward priority.** `Rs1_EX`=7, `Rd_MEM`=7, `Rd_WB`=7, both write enables 1 -> `fwdA_sel`=10. With `RegWEn_MEM`=0 -> 01. With all `Rd`=0 -> 00.
- **Memory wait.** `dmem_req_MEM`=1, `dmem_ack`=0 for 3 cycles, then 1 -> four holds + `clear_MEM_WB` for 3 cycles; state returns to RUN; `wait_cnt`=3. A concurrent `PCsel_EX`=1 flushes only in the ack cycle.
- **Timeout.** `MEM_TIMEOUT`=4, `dmem_ack` held 0 -> FAULT after the 4th wait cycle; `mem_fault`=1; holds stay 1 even if `dmem_ack` later rises. Synchronous `rst` -> RUN, `mem_fault`=0, counters 0.
- **Saturation.** `CNT_W`=2, 5 consecutive load-use events -> `stall_cnt` stops at 3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: load-use stalls,
// EX-resolved branch flushes, data-memory wait states with timeout, and perf counters.
module hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_ID,
    input  logic [4:0]       Rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic [4:0]       Rd_EX,
    input  logic [4:0]       Rs1_EX,
    input  logic [4:0]       Rs2_EX,
    input  logic             RegWEn_EX,
    input  logic [1:0]       WBSel_EX,
    input  logic             PCsel_EX,
    input  logic [4:0]       Rd_MEM,
    input  logic [4:0]       Rd_WB,
    input  logic             RegWEn_MEM,
    input  logic             RegWEn_WB,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ack,
    output logic             hold_PC,
    output logic             hold_IF_ID,
    output logic             hold_ID_EX,
    output logic             hold_EX_MEM,
    output logic             clear_IF_ID,
    output logic             clear_ID_EX,
    output logic             clear_MEM_WB,
    output logic [1:0]       fwdA_sel,
    output logic [1:0]       fwdB_sel,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_WAIT  = 2'b01;
    localparam logic [1:0] ST_FAULT = 2'b10;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [15:0] wait_timer;
    logic        mw;
    logic        lu;
    logic        br;
    logic        is_stall;
    logic        is_flush;
    logic        timeout_hit;

    // Memory handshake: the MEM stage raises dmem_req_MEM and keeps it up until the
    // cycle in which dmem_ack is 1; that cycle completes the access and releases the pipe.
    assign mw = dmem_req_MEM & ~dmem_ack;
    assign br = PCsel_EX;
    assign lu = RegWEn_EX & (WBSel_EX == 2'b01) & (Rd_EX != 5'd0) &
                ((use_rs1_ID & (Rd_EX == Rs1_ID)) | (use_rs2_ID & (Rd_EX == Rs2_ID)));

    // Counts the ack-less WAIT cycles including the current one.
    assign timeout_hit = ({1'b0, wait_timer} + 17'd1) == 17'(MEM_TIMEOUT);
    assign state_dbg   = state;

    always_comb begin
        hold_PC      = 1'b0;
        hold_IF_ID   = 1'b0;
        hold_ID_EX   = 1'b0;
        hold_EX_MEM  = 1'b0;
        clear_IF_ID  = 1'b0;
        clear_ID_EX  = 1'b0;
        clear_MEM_WB = 1'b0;
        is_stall     = 1'b0;
        is_flush     = 1'b0;
        if (!rst) begin
            if (state == ST_FAULT) begin
                hold_PC     = 1'b1;
                hold_IF_ID  = 1'b1;
                hold_ID_EX  = 1'b1;
                hold_EX_MEM = 1'b1;
            end else if (mw) begin
                hold_PC      = 1'b1;
                hold_IF_ID   = 1'b1;
                hold_ID_EX   = 1'b1;
                hold_EX_MEM  = 1'b1;
                clear_MEM_WB = 1'b1;
            end else if (br) begin
                clear_IF_ID = 1'b1;
                clear_ID_EX = 1'b1;
                is_flush    = 1'b1;
            end else if (lu) begin
                hold_PC     = 1'b1;
                hold_IF_ID  = 1'b1;
                clear_ID_EX = 1'b1;
                is_stall    = 1'b1;
            end
        end
    end

    // MEM stage holds the younger result, so it wins over WB.
    always_comb begin
        fwdA_sel = 2'b00;
        fwdB_sel = 2'b00;
        if (!rst) begin
            if (RegWEn_MEM && Rd_MEM != 5'd0 && Rd_MEM == Rs1_EX)     fwdA_sel = 2'b10;
            else if (RegWEn_WB && Rd_WB != 5'd0 && Rd_WB == Rs1_EX)   fwdA_sel = 2'b01;
            if (RegWEn_MEM && Rd_MEM != 5'd0 && Rd_MEM == Rs2_EX)     fwdB_sel = 2'b10;
            else if (RegWEn_WB && Rd_WB != 5'd0 && Rd_WB == Rs2_EX)   fwdB_sel = 2'b01;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (mw) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (dmem_ack)         state_nxt = ST_RUN;
                else if (timeout_hit) state_nxt = ST_FAULT;
            end
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            wait_timer <= 16'd0;
            mem_fault  <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            wait_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_RUN)
                wait_timer <= 16'd0;
            else if (state == ST_WAIT && !dmem_ack)
                wait_timer <= wait_timer + 16'd1;
            if (state_nxt == ST_FAULT)
                mem_fault <= 1'b1;
            if (state != ST_FAULT) begin
                if (is_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
                if (is_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
                if (mw && wait_cnt != '1)        wait_cnt  <= wait_cnt + 1'b1;
            end
        end
    end

endmodule
